// File: rtl/shift_add_multiplier_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier controller.
// Drives an external shared 16-bit adder and registers its sum and carry each RUN cycle.
module shift_add_multiplier_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic [15:0] adder_operand1,
    output logic [15:0] adder_operand2,
    input  logic [15:0] adder_sum,
    input  logic        adder_carry,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] q_q, q_d;
    logic [15:0] b_q, b_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] product_q, product_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= 16'h0000;
            q_q       <= 16'h0000;
            b_q       <= 16'h0000;
            count_q   <= 4'd0;
            product_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            b_q       <= b_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        q_d            = q_q;
        b_d            = b_q;
        count_d        = count_q;
        product_d      = product_q;
        adder_operand1 = 16'h0000;
        adder_operand2 = 16'h0000;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = 16'h0000;
                    q_d     = multiplier;
                    b_d     = multiplicand;
                    count_d = 4'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                adder_operand1 = a_q;
                adder_operand2 = q_q[0] ? b_q : 16'h0000;
                // Carry lands in A[15]; the sum's LSB shifts into Q[15].
                a_d     = {adder_carry, adder_sum[15:1]};
                q_d     = {adder_sum[0], q_q[15:1]};
                count_d = count_q + 4'd1;
                if (count_q == 4'd15) begin
                    product_d = {a_d, q_d};
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// Directed bench for shift_add_multiplier_ctrl; models the shared adder as a 17-bit sum.
module tb_shift_add_multiplier_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [15:0] adder_operand1;
    logic [15:0] adder_operand2;
    logic [15:0] adder_sum;
    logic        adder_carry;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .adder_operand1 (adder_operand1),
        .adder_operand2 (adder_operand2),
        .adder_sum      (adder_sum),
        .adder_carry    (adder_carry),
        .busy           (busy),
        .done           (done),
        .product        (product)
    );

    assign {adder_carry, adder_sum} = {1'b0, adder_operand1} + {1'b0, adder_operand2};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full multiply: checks first-cycle operands, busy for 16 cycles, done on the 17th.
    task automatic mult(input string tag, input logic [15:0] b, input logic [15:0] q,
                        input logic [31:0] exp, input logic [15:0] op2_first,
                        input bit op2_always_zero);
        @(negedge clk);
        multiplicand = b;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 16'hA5A5;
        multiplier   = 16'h5A5A;
        chk({tag, "_op1_first"}, {16'h0, adder_operand1}, 32'h0);
        chk({tag, "_op2_first"}, {16'h0, adder_operand2}, {16'h0, op2_first});
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_busy"}, {30'h0, busy, done}, 32'h2);
            if (op2_always_zero) chk({tag, "_op2_zero"}, {16'h0, adder_operand2}, 32'h0);
            @(negedge clk);
        end
        chk({tag, "_done"}, {30'h0, busy, done}, 32'h1);
        chk({tag, "_product"}, product, exp);
        chk({tag, "_ops_done"}, {adder_operand1, adder_operand2}, 32'h0);
        @(negedge clk);
        chk({tag, "_idle"}, {30'h0, busy, done}, 32'h0);
        chk({tag, "_held"}, product, exp);
    endtask

    initial begin
        int ndone;
        int t;
        int pulses [$];
        logic [31:0] last_prod;

        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = 16'h0;
        multiplier   = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_flags", {30'h0, busy, done}, 32'h0);
        chk("rst_product", product, 32'h0);
        chk("rst_ops", {adder_operand1, adder_operand2}, 32'h0);

        mult("m3x5", 16'd3, 16'd5, 32'h0000_000F, 16'd3, 1'b0);
        mult("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16'hFFFF, 1'b0);
        mult("m0x1234", 16'h0000, 16'h1234, 32'h0, 16'h0, 1'b0);
        mult("m1234x0", 16'h1234, 16'h0000, 32'h0, 16'h0, 1'b1);

        // 2x2 with a 7x9 start pulse mid-RUN that must be dropped.
        @(negedge clk);
        multiplicand = 16'd2;
        multiplier   = 16'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        multiplicand = 16'd7;
        multiplier   = 16'd9;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        last_prod = 32'hDEAD_BEEF;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ndone++;
                last_prod = product;
            end
            @(negedge clk);
        end
        chk("drop_ndone", ndone, 1);
        chk("drop_product", last_prod, 32'h4);
        chk("drop_idle", {30'h0, busy, done}, 32'h0);

        // Reset at RUN cycle 8 of 100x200, with start asserted alongside reset.
        multiplicand = 16'd100;
        multiplier   = 16'd200;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("abort_flags", {30'h0, busy, done}, 32'h0);
        chk("abort_product", product, 32'h0);
        chk("abort_ops", {adder_operand1, adder_operand2}, 32'h0);
        @(negedge clk);
        chk("abort_stay_idle", {30'h0, busy, done}, 32'h0);
        mult("m100x200", 16'd100, 16'd200, 32'h0000_4E20, 16'h0, 1'b0);

        // Start held high: one done every 18 cycles.
        @(negedge clk);
        multiplicand = 16'h8000;
        multiplier   = 16'd2;
        start        = 1'b1;
        for (t = 0; t < 64; t++) begin
            @(negedge clk);
            if (done) begin
                pulses.push_back(t);
                chk("hold_product", product, 32'h0001_0000);
            end
        end
        start = 1'b0;
        chk("hold_npulses", pulses.size(), 3);
        if (pulses.size() >= 3) begin
            chk("hold_period1", pulses[1] - pulses[0], 18);
            chk("hold_period2", pulses[2] - pulses[1], 18);
        end
        chk("hold_first_latency", (pulses.size() > 0) ? pulses[0] : -1, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
